// File: rtl/si570_prog_seq.sv
// si570_prog_seq: turns a start request into the Si570 freeze/program/unfreeze/NewFreq/settle
// or read-back sequence, one byte-register transaction at a time.
module si570_prog_seq #(
  parameter int POLL_LIMIT = 16,
  parameter int MAX_RETRY = 3,
  parameter int SETTLE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_write,
  input  logic        start_read,
  input  logic [2:0]  hs_div,
  input  logic [6:0]  n1,
  input  logic [37:0] rfreq,
  output logic        xfer_valid,
  input  logic        xfer_ready,
  output logic        xfer_write,
  output logic [7:0]  xfer_addr,
  output logic [7:0]  xfer_wdata,
  input  logic        resp_valid,
  input  logic        resp_err,
  input  logic [7:0]  resp_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  cur_hs_div,
  output logic [6:0]  cur_n1,
  output logic [37:0] cur_rfreq
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [3:0] {
    IDLE, FREEZE, WR_REG, UNFREEZE, NEWFREQ, POLL, SETTLE, RD_REG, ABORT_UNF, DONE, ERROR
  } state_t;
  state_t state;
  logic [47:0] cfg;
  logic [2:0] idx;
  logic pend;
  logic [RW-1:0] retry;
  logic [PW-1:0] poll;
  logic [SW-1:0] settle;
  logic req_write;
  logic [7:0] req_addr, req_wdata;
  logic [47:0] rd_all;
  // cfg doubles as the outgoing byte shifter (writes) and the read-back shadow (reads)
  always_comb begin
    req_write = !(state == POLL || state == RD_REG);
    req_addr = (state == WR_REG || state == RD_REG) ? 8'd7 + {5'd0, idx} :
               (state == NEWFREQ || state == POLL) ? 8'd135 : 8'd137;
    req_wdata = state == FREEZE ? 8'h10 : state == WR_REG ? cfg[47:40] :
                state == NEWFREQ ? 8'h40 : 8'h00;
    rd_all = {cfg[39:0], resp_rdata};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cfg <= '0;
      idx <= '0;
      pend <= 1'b0;
      retry <= '0;
      poll <= '0;
      settle <= '0;
      xfer_valid <= 1'b0;
      xfer_write <= 1'b0;
      xfer_addr <= '0;
      xfer_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      cur_hs_div <= '0;
      cur_n1 <= '0;
      cur_rfreq <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start_write || start_read) begin
          error <= 1'b0;
          busy <= 1'b1;
          cfg <= {hs_div, n1, rfreq};
          idx <= '0;
          retry <= '0;
          poll <= '0;
          settle <= '0;
          state <= start_write ? FREEZE : RD_REG;
        end
        SETTLE: if (settle == SW'(SETTLE_CYCLES - 1)) begin
          settle <= '0;
          done <= 1'b1;
          busy <= 1'b0;
          state <= DONE;
        end else settle <= settle + 1'b1;
        DONE: state <= IDLE;
        ERROR: state <= IDLE;
        default: if (!xfer_valid && !pend) begin
          xfer_valid <= 1'b1;
          xfer_write <= req_write;
          xfer_addr <= req_addr;
          xfer_wdata <= req_wdata;
        end else if (xfer_valid && xfer_ready) begin
          xfer_valid <= 1'b0;
          pend <= 1'b1;
        end else if (pend && resp_valid) begin
          pend <= 1'b0;
          if (state == ABORT_UNF) begin
            error <= 1'b1;
            busy <= 1'b0;
            state <= ERROR;
          end else if (resp_err) begin
            if (retry == RW'(MAX_RETRY)) begin
              retry <= '0;
              if (state == WR_REG) state <= ABORT_UNF;
              else begin
                error <= 1'b1;
                busy <= 1'b0;
                state <= ERROR;
              end
            end else retry <= retry + 1'b1;
          end else begin
            retry <= '0;
            case (state)
              FREEZE: state <= WR_REG;
              WR_REG: begin
                cfg <= {cfg[39:0], 8'h00};
                idx <= idx + 1'b1;
                if (idx == 3'd5) state <= UNFREEZE;
              end
              UNFREEZE: state <= NEWFREQ;
              NEWFREQ: state <= POLL;
              POLL: if (!resp_rdata[6]) state <= SETTLE;
              else if (poll == PW'(POLL_LIMIT - 1)) begin
                error <= 1'b1;
                busy <= 1'b0;
                state <= ERROR;
              end else poll <= poll + 1'b1;
              RD_REG: begin
                cfg <= rd_all;
                idx <= idx + 1'b1;
                if (idx == 3'd5) begin
                  {cur_hs_div, cur_n1, cur_rfreq} <= rd_all;
                  done <= 1'b1;
                  busy <= 1'b0;
                  state <= DONE;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_si570_prog_seq.sv
// tb_si570_prog_seq: randomized checks of si570_prog_seq against a transaction-list model and engine stub
module tb_si570_prog_seq;
  localparam int PL = 16, MR = 3, SC = 20;
  logic clk = 0, reset = 1, start_write = 0, start_read = 0;
  logic [2:0] hs_div = 0;
  logic [6:0] n1 = 0;
  logic [37:0] rfreq = 0;
  logic xfer_valid, xfer_ready = 0, xfer_write;
  logic [7:0] xfer_addr, xfer_wdata;
  logic resp_valid = 0, resp_err = 0;
  logic [7:0] resp_rdata = 0;
  logic busy, done, error;
  logic [2:0] cur_hs_div;
  logic [6:0] cur_n1;
  logic [37:0] cur_rfreq;
  int checks = 0, errors = 0, cyc = 0;
  int stall_left = 0, err_addr = -1, err_cnt = 0, err_left = 0, last_resp_cyc = 0, m_err_left = 0;
  bit poll_busy = 0, resp_sched = 0, stalled = 0, exp_ok = 0, m_abort = 0;
  logic [7:0] rd [6];
  logic resp_e;
  logic [7:0] resp_d;
  logic [16:0] stall_fields;
  logic [16:0] log_q[$], exp_q[$];
  logic [47:0] cur_model = 0;

  si570_prog_seq #(.POLL_LIMIT(PL), .MAX_RETRY(MR), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .start_write(start_write), .start_read(start_read),
    .hs_div(hs_div), .n1(n1), .rfreq(rfreq), .xfer_valid(xfer_valid), .xfer_ready(xfer_ready),
    .xfer_write(xfer_write), .xfer_addr(xfer_addr), .xfer_wdata(xfer_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata), .busy(busy),
    .done(done), .error(error), .cur_hs_div(cur_hs_div), .cur_n1(cur_n1), .cur_rfreq(cur_rfreq));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // engine stub: optional stall, then a response on the cycle after acceptance
  initial forever begin
    @(negedge clk);
    resp_valid = 0; resp_err = 0; resp_rdata = 0;
    if (resp_sched) begin
      resp_valid = 1; resp_err = resp_e; resp_rdata = resp_d; resp_sched = 0; last_resp_cyc = cyc;
    end
    xfer_ready = (stall_left == 0);
    if (xfer_valid) begin
      if (stalled) begin
        checks++;
        if ({xfer_write, xfer_addr, xfer_wdata} !== stall_fields) begin
          errors++;
          $display("FAIL stable: fields=%h, required %h", {xfer_write, xfer_addr, xfer_wdata}, stall_fields);
        end
      end
      if (!xfer_ready) begin
        stall_left--; stalled = 1; stall_fields = {xfer_write, xfer_addr, xfer_wdata};
      end else begin
        stalled = 0;
        log_q.push_back({xfer_write, xfer_addr, xfer_wdata});
        resp_sched = 1;
        resp_e = (int'(xfer_addr) == err_addr && err_left > 0);
        if (resp_e) err_left--;
        resp_d = (xfer_addr == 8'd135) ? (poll_busy ? 8'h40 : 8'h00) :
                 (xfer_addr >= 8'd7 && xfer_addr <= 8'd12) ? rd[xfer_addr - 8'd7] : 8'h00;
      end
    end else stalled = 0;
  end

  task automatic m_add(input bit w, input logic [7:0] a, input logic [7:0] d);
    int fails = 0;
    forever begin
      exp_q.push_back({w, a, d});
      if (int'(a) == err_addr && m_err_left > 0) begin
        m_err_left--; fails++;
        if (fails > MR) begin m_abort = 1; return; end
      end else return;
    end
  endtask

  task automatic model_write(input logic [47:0] c);
    exp_q.delete(); m_abort = 0; m_err_left = err_cnt; exp_ok = 0;
    m_add(1, 8'd137, 8'h10);
    if (m_abort) return;
    for (int i = 0; i < 6; i++) begin
      m_add(1, 8'(7 + i), c[47 - 8 * i -: 8]);
      if (m_abort) begin exp_q.push_back({1'b1, 8'd137, 8'h00}); return; end
    end
    m_add(1, 8'd137, 8'h00);
    if (m_abort) return;
    m_add(1, 8'd135, 8'h40);
    if (m_abort) return;
    for (int p = 0; p < PL; p++) begin
      m_add(0, 8'd135, 8'h00);
      if (m_abort) return;
      if (!poll_busy) begin exp_ok = 1; return; end
    end
  endtask

  task automatic model_read();
    exp_q.delete(); m_abort = 0; m_err_left = err_cnt;
    for (int i = 0; i < 6; i++) if (!m_abort) m_add(0, 8'(7 + i), 8'h00);
    exp_ok = !m_abort;
  endtask

  task automatic run_seq(input bit w, input logic [47:0] c, input string nm);
    logic [47:0] prev_cur, exp_cur, got;
    logic [16:0] g, e;
    int done_cyc = 0, quiet = 0;
    bit ended = 0, got_done = 0;
    if (w) model_write(c); else model_read();
    log_q.delete(); err_left = err_cnt;
    @(negedge clk); start_write = w; start_read = !w; {hs_div, n1, rfreq} = c;
    @(negedge clk); start_write = 0; start_read = 0;
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL %s start: busy=%b error=%b, required busy=1 error=0", nm, busy, error);
    end
    prev_cur = {cur_hs_div, cur_n1, cur_rfreq};
    for (int i = 0; i < 3000 && !ended; i++) begin
      @(negedge clk);
      if (done || error) begin ended = 1; got_done = done; done_cyc = cyc; end
      else prev_cur = {cur_hs_div, cur_n1, cur_rfreq};
    end
    checks++;
    if (!ended) begin
      errors++; $display("FAIL %s timeout: no done/error within 3000 cycles", nm);
      return;
    end
    if (got_done !== exp_ok || busy !== 1'b0) begin
      errors++; $display("FAIL %s outcome: done=%b busy=%b, required done=%b busy=0", nm, got_done, busy, exp_ok);
    end
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s count: %0d transactions, required %0d", nm, log_q.size(), exp_q.size());
    end
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      g = log_q[i]; e = exp_q[i];
      if (!e[16]) g[7:0] = 8'h00;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s xfer%0d: %h, required %h", nm, i, g, e); end
    end
    if (w && exp_ok) begin
      checks++;
      if (done_cyc - last_resp_cyc != SC + 1) begin
        errors++; $display("FAIL %s settle: %0d cycles, required %0d", nm, done_cyc - last_resp_cyc, SC + 1);
      end
    end
    if (!w) begin
      exp_cur = exp_ok ? {rd[0], rd[1], rd[2], rd[3], rd[4], rd[5]} : cur_model;
      got = {cur_hs_div, cur_n1, cur_rfreq};
      checks++;
      if (got !== exp_cur) begin errors++; $display("FAIL %s cur: %h, required %h", nm, got, exp_cur); end
      checks++;
      if (prev_cur !== cur_model) begin
        errors++; $display("FAIL %s cur_early: %h before done, required %h", nm, prev_cur, cur_model);
      end
      cur_model = exp_cur;
    end
    repeat (3) begin
      @(negedge clk);
      if (done || xfer_valid || busy) quiet++;
    end
    checks++;
    if (quiet != 0) begin errors++; $display("FAIL %s idle: %0d active cycles after end, required 0", nm, quiet); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({xfer_valid, xfer_write, xfer_addr, xfer_wdata, busy, done, error, cur_hs_div, cur_n1, cur_rfreq} !== '0) begin
      errors++; $display("FAIL reset: outputs nonzero busy=%b valid=%b error=%b", busy, xfer_valid, error);
    end
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || xfer_valid !== 1'b0) begin
      errors++; $display("FAIL idle: busy=%b valid=%b, required 0 0", busy, xfer_valid);
    end
  endtask

  task automatic test_write_basic();
    err_addr = -1; err_cnt = 0; poll_busy = 0;
    run_seq(1, {3'b001, 7'h07, 38'h02_BC01_1EB8}, "write_basic");
  endtask

  task automatic test_read_basic();
    err_addr = -1; err_cnt = 0;
    rd[0] = 8'h01; rd[1] = 8'hC2; rd[2] = 8'hBC; rd[3] = 8'h01; rd[4] = 8'h1E; rd[5] = 8'hB8;
    run_seq(0, 48'h0, "read_basic");
  endtask

  task automatic test_retry();
    err_addr = 9; err_cnt = 2; poll_busy = 0;
    run_seq(1, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, "retry");
  endtask

  task automatic test_abort();
    err_addr = 10; err_cnt = 4; poll_busy = 0;
    run_seq(1, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, "abort_write");
    err_addr = 9; err_cnt = 4;
    for (int i = 0; i < 6; i++) rd[i] = 8'($urandom);
    run_seq(0, 48'h0, "abort_read");
  endtask

  task automatic test_poll_timeout();
    err_addr = -1; err_cnt = 0; poll_busy = 1;
    run_seq(1, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, "poll_timeout");
    poll_busy = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      err_addr = 7 + $urandom_range(0, 5); err_cnt = $urandom_range(0, 3);
      for (int i = 0; i < 6; i++) rd[i] = 8'($urandom);
      run_seq(1'($urandom), {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, "random");
    end
  endtask

  task automatic test_stall_reset();
    logic [47:0] c;
    logic [16:0] g;
    int n, busy_cnt = 0;
    bit seen = 0;
    c = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    err_addr = -1; err_cnt = 0; err_left = 0; poll_busy = 0;
    model_write(c); log_q.delete(); stall_left = 5;
    @(negedge clk); start_write = 1; {hs_div, n1, rfreq} = c;
    @(negedge clk); start_write = 0;
    @(negedge clk); start_read = 1;
    @(negedge clk); start_read = 0; start_write = 1; {hs_div, n1, rfreq} = ~c;
    @(negedge clk); start_write = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (log_q.size() >= 4) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_reset timeout: %0d transactions, required 4", log_q.size()); end
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    checks++;
    if ({xfer_valid, xfer_write, xfer_addr, xfer_wdata, busy, done, error, cur_hs_div, cur_n1, cur_rfreq} !== '0) begin
      errors++; $display("FAIL stall_reset outputs: busy=%b valid=%b addr=%h, required all 0", busy, xfer_valid, xfer_addr);
    end
    n = log_q.size();
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      g = log_q[i];
      checks++;
      if (g !== exp_q[i]) begin errors++; $display("FAIL stall_reset xfer%0d: %h, required %h", i, g, exp_q[i]); end
    end
    repeat (30) begin
      @(negedge clk);
      if (xfer_valid || busy) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 0 || log_q.size() != n) begin
      errors++; $display("FAIL stall_reset quiet: %0d active cycles, %0d new xfers, required 0 0", busy_cnt, log_q.size() - n);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_retry();
    test_abort();
    test_poll_timeout();
    test_random();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
